// File: rtl/std_dffre_sync_pkg.sv
// Shared constants for instantiators of the std_dffre_sync register primitive.
// The register itself does not import this package.
package std_dffre_sync_pkg;

    localparam int COUNTER_WIDTH = 64;
    localparam int MAX_WIDTH     = 1024;

    function automatic bit width_legal(input int w);
        return (w >= 1) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/std_dffre_sync_if.sv
// Load-enable/data/state bundle for one std_dffre_sync instance; clk and rstn stay separate.
// The driver of en/d uses modport master, the register side uses modport slave.
interface std_dffre_sync_if
    import std_dffre_sync_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
);

    logic             en;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    modport master (output en, output d, input q);
    modport slave  (input en, input d, output q);

endinterface

// File: rtl/std_dffre_sync.sv
// WIDTH-bit register with synchronous active-low reset (rstn) and load enable (en).
// Define STD_DFFRE_SYNC_XCHECK_EN to add simulation-only X/Z checks on rstn, en and d.
module std_dffre_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

`ifdef STD_DFFRE_SYNC_XCHECK_EN
    // An unknown enable poisons q so the corruption is visible downstream.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= RESET_VAL;
        end else if ($isunknown(en)) begin
            q <= 'x;
        end else if (en) begin
            q <= d;
        end
    end

    always @(posedge clk) begin
        if ($isunknown(rstn)) begin
            $error("%m: rstn unknown at time %0t", $time);
        end else if (rstn === 1'b1) begin
            if ($isunknown(en)) begin
                $error("%m: en unknown while out of reset at time %0t", $time);
            end else if ((en === 1'b1) && $isunknown(d)) begin
                $error("%m: d contains X/Z while loading at time %0t", $time);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end
`endif

endmodule

// File: tb/tb_std_dffre_sync.sv
// Scoreboard bench for std_dffre_sync: 64-bit, 8-bit free-running counter and 4-bit nonzero-reset instances.
module tb_std_dffre_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn0 = 1'b1;
    logic rstn1 = 1'b1;
    logic rstn2 = 1'b1;

    std_dffre_sync_if #(.WIDTH(64)) reg_if ();
    std_dffre_sync_if #(.WIDTH(8))  cnt_if ();
    std_dffre_sync_if #(.WIDTH(4))  rv_if  ();

    // The counter instance feeds its own output back, incremented and wrapped by the caller.
    assign cnt_if.d = cnt_if.q + 8'd1;

    std_dffre_sync #(.WIDTH(64), .RESET_VAL(64'h0)) dut_reg (
        .clk  (clk),
        .rstn (rstn0),
        .en   (reg_if.en),
        .d    (reg_if.d),
        .q    (reg_if.q)
    );

    std_dffre_sync #(.WIDTH(8), .RESET_VAL(8'h00)) dut_cnt (
        .clk  (clk),
        .rstn (rstn1),
        .en   (cnt_if.en),
        .d    (cnt_if.d),
        .q    (cnt_if.q)
    );

    std_dffre_sync #(.WIDTH(4), .RESET_VAL(4'hC)) dut_rv (
        .clk  (clk),
        .rstn (rstn2),
        .en   (rv_if.en),
        .d    (rv_if.d),
        .q    (rv_if.q)
    );

    typedef struct {
        int          dut;
        logic [63:0] expected;
        int          cyc;
        string       name;
    } item_t;

    item_t sb[$];
    int    cycle = 0;
    int    total = 0;
    int    bad   = 0;

    task automatic pushExpect(input int dut, input logic [63:0] expected, input string name);
        item_t it;
        it.dut      = dut;
        it.expected = expected;
        it.cyc      = cycle + 1;
        it.name     = name;
        sb.push_back(it);
    endtask

    task automatic applyStimulus(input int dut, input bit rst_n, input bit en,
                                 input logic [63:0] d, input logic [63:0] expected,
                                 input string name);
        @(negedge clk);
        case (dut)
            0: begin rstn0 = rst_n; reg_if.en = en; reg_if.d = d; end
            1: begin rstn1 = rst_n; cnt_if.en = en; end
            default: begin rstn2 = rst_n; rv_if.en = en; rv_if.d = d[3:0]; end
        endcase
        pushExpect(dut, expected, name);
    endtask

    task automatic checkOutput(input item_t it);
        logic [63:0] act;
        case (it.dut)
            0:       act = reg_if.q;
            1:       act = {56'h0, cnt_if.q};
            default: act = {60'h0, rv_if.q};
        endcase
        total++;
        if (act !== it.expected) begin
            bad++;
            $display("[TB] FAIL %s: dut%0d got %h expected %h", it.name, it.dut, act, it.expected);
        end
    endtask

    // Monitor: each item is due one edge after the negedge that issued it.
    always begin
        @(posedge clk);
        cycle = cycle + 1;
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cycle) begin
            checkOutput(sb.pop_front());
        end
    end

    initial begin
        reg_if.en = 1'b0;
        reg_if.d  = '0;
        cnt_if.en = 1'b0;
        rv_if.en  = 1'b0;
        rv_if.d   = '0;

        // 64-bit register: reset priority, release, load and hold.
        applyStimulus(0, 1'b0, 1'b0, 64'h0,                  64'h0,                  "reset0");
        applyStimulus(0, 1'b1, 1'b1, 64'hDEAD_BEEF,          64'hDEAD_BEEF,          "preload");
        applyStimulus(0, 1'b0, 1'b1, 64'h1234,               64'h0,                  "rst_over_en");
        applyStimulus(0, 1'b1, 1'b1, 64'h1234,               64'h1234,               "reset_release");
        applyStimulus(0, 1'b1, 1'b1, 64'hA5,                 64'hA5,                 "load_a5");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 64'h5A,             64'hA5,                 "hold");
        end
        applyStimulus(0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "load_ones");
        applyStimulus(0, 1'b1, 1'b1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, "load_msb_lsb");

        // A brief rstn glitch between edges must not disturb q.
        @(negedge clk);
        reg_if.en = 1'b0;
        reg_if.d  = 64'h0;
        #2 rstn0 = 1'b0;
        #1 rstn0 = 1'b1;
        pushExpect(0, 64'h8000_0000_0000_0001, "async_rst_immune");

        // Only the d value present at the edge is captured.
        @(negedge clk);
        reg_if.en = 1'b1;
        reg_if.d  = 64'h1111;
        #2 reg_if.d = 64'h2222;
        #2 reg_if.d = 64'h3333;
        pushExpect(0, 64'h3333, "d_edge_sample");
        applyStimulus(0, 1'b1, 1'b0, 64'h4444,               64'h3333,               "hold_after_toggle");

        // 8-bit counter: reset, then 260 increments wrap through zero to 4.
        applyStimulus(1, 1'b0, 1'b1, 64'h0, 64'h0, "cnt_reset");
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1, 1'b1, 1'b1, 64'h0, 64'((i + 1) % 256), "cnt_step");
        end
        applyStimulus(1, 1'b1, 1'b0, 64'h0, 64'h4, "cnt_final_hold");

        // 4-bit register with reset value 0xC.
        applyStimulus(2, 1'b0, 1'b0, 64'h0, 64'hC, "rv_reset");
        applyStimulus(2, 1'b1, 1'b1, 64'h5, 64'h5, "rv_load5");
        applyStimulus(2, 1'b0, 1'b1, 64'h3, 64'hC, "rv_mid_pulse");
        applyStimulus(2, 1'b1, 1'b1, 64'h3, 64'h3, "rv_resume");
        applyStimulus(2, 1'b1, 1'b0, 64'h9, 64'h3, "rv_hold");
        applyStimulus(2, 1'b1, 1'b1, 64'hF, 64'hF, "rv_load_f");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: %0d checks outstanding, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
